// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream op handshake, ALU-side handshake and bypass feedback for alu_issue_stage
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluctl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_illegal;
    modport master (
        output in_valid, in_aluop, in_funct, in_a, in_b, in_rs, in_rt, in_rd, alu_result, out_ready,
        input  in_ready, out_valid, out_aluctl, out_a, out_b, out_rd, out_illegal
    );
    modport slave (
        input  in_valid, in_aluop, in_funct, in_a, in_b, in_rs, in_rt, in_rd, alu_result, out_ready,
        output in_ready, out_valid, out_aluctl, out_a, out_b, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ALU control decode with a 2-entry skid buffer (OUT + SKID).
// Optional result bypass into stored operands when ALU_ISSUE_FORWARD_EN is defined.
module alu_issue_stage (
    input logic clk,
    input logic rst_n,
    alu_issue_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [3:0]  ctl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } entry_t;
    state_t state, state_nx;
    entry_t out_q, skid_q, new_e;
    logic accept, consume, byp_a, byp_b;
    logic [3:0] fctl;
    assign bus.in_ready    = state != FULL;
    assign bus.out_valid   = state != EMPTY;
    assign accept          = bus.in_valid && bus.in_ready;
    assign consume         = bus.out_valid && bus.out_ready;
    assign bus.out_aluctl  = out_q.ctl;
    assign bus.out_illegal = out_q.ill;
    assign bus.out_a       = out_q.a;
    assign bus.out_b       = out_q.b;
    assign bus.out_rd      = out_q.rd;
`ifdef ALU_ISSUE_FORWARD_EN
    // OUT holds the op the ALU is computing now, so its result is current for a dependent op
    assign byp_a = state != EMPTY && out_q.rd != 5'd0 && bus.in_rs == out_q.rd;
    assign byp_b = state != EMPTY && out_q.rd != 5'd0 && bus.in_rt == out_q.rd;
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.in_rs, bus.in_rt, bus.alu_result};
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif
    always_comb begin
        fctl = bus.in_funct == 6'h24 ? 4'd0 :
               bus.in_funct == 6'h25 ? 4'd1 :
               bus.in_funct == 6'h20 ? 4'd2 :
               bus.in_funct == 6'h22 ? 4'd6 :
               bus.in_funct == 6'h2A ? 4'd7 :
               bus.in_funct == 6'h27 ? 4'd12 : 4'd15;
        new_e.ctl = bus.in_aluop == 2'b00 ? 4'd2 :
                    bus.in_aluop == 2'b01 ? 4'd6 :
                    bus.in_aluop == 2'b11 ? 4'd1 : fctl;
        new_e.ill = bus.in_aluop == 2'b10 && fctl == 4'd15;
        new_e.a   = byp_a ? bus.alu_result : bus.in_a;
        new_e.b   = byp_b ? bus.alu_result : bus.in_b;
        new_e.rd  = bus.in_rd;
    end
    always_comb begin
        state_nx = state == EMPTY ? (accept ? ONE : EMPTY) :
                   state == ONE   ? (accept == consume ? ONE : accept ? FULL : EMPTY) :
                                    (consume ? ONE : FULL);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (state == FULL ? consume : accept && (state == EMPTY || consume))
                out_q <= state == FULL ? skid_q : new_e;
            if (state == ONE && accept && !consume)
                skid_q <= new_e;
        end
    end
endmodule
